// File: rtl/bank_cmd_scheduler.sv
// Expands one decoded memory request into PRECHARGE -> ACTIVATE -> READ/WRITE pulses,
// tracking the open row of every bank and spacing commands by fixed latencies.
module bank_cmd_scheduler #(
    parameter int ROW_BITS           = 8,
    parameter int COL_BITS           = 4,
    parameter int BANK_GROUPS        = 4,
    parameter int BANKS_PER_GROUP    = 2,
    parameter int ACTIVATION_LATENCY = 8,
    parameter int PRECHARGE_LATENCY  = 5,
    parameter int BURST_CYCLES       = 8
) (
    input  logic                               clk_in,
    input  logic                               rst_in,
    input  logic                               req_valid_in,
    output logic                               req_ready_out,
    input  logic                               req_write_in,
    input  logic [ROW_BITS-1:0]                req_row_in,
    input  logic [COL_BITS-1:0]                req_col_in,
    input  logic [$clog2(BANK_GROUPS)-1:0]     req_bg_in,
    input  logic [$clog2(BANKS_PER_GROUP)-1:0] req_ba_in,
    input  logic [7:0][63:0]                   req_data_in,
    output logic                               cmd_valid_out,
    output logic [2:0]                         cmd_out,
    output logic [$clog2(BANK_GROUPS)-1:0]     cmd_bg_out,
    output logic [$clog2(BANKS_PER_GROUP)-1:0] cmd_ba_out,
    output logic [ROW_BITS-1:0]                cmd_row_out,
    output logic [COL_BITS-1:0]                cmd_col_out,
    output logic [7:0][63:0]                   cmd_data_out,
    output logic [31:0]                        hit_count_out,
    output logic [31:0]                        miss_count_out,
    output logic [31:0]                        conflict_count_out
);
    localparam int BG_W  = $clog2(BANK_GROUPS);
    localparam int BA_W  = $clog2(BANKS_PER_GROUP);
    localparam int NB    = BANK_GROUPS * BANKS_PER_GROUP;
    localparam int CNT_W = 16;

    localparam logic [2:0] CMD_READ  = 3'd0;
    localparam logic [2:0] CMD_WRITE = 3'd1;
    localparam logic [2:0] CMD_ACT   = 3'd2;
    localparam logic [2:0] CMD_PRE   = 3'd3;
    localparam logic [2:0] CMD_NONE  = 3'b111;

    localparam logic [CNT_W-1:0] PRE_LOAD   = CNT_W'(PRECHARGE_LATENCY - 1);
    localparam logic [CNT_W-1:0] ACT_LOAD   = CNT_W'(ACTIVATION_LATENCY - 1);
    localparam logic [CNT_W-1:0] BURST_LOAD = CNT_W'(BURST_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_DECIDE     = 3'd1,
        ST_PRE_WAIT   = 3'd2,
        ST_ACT_WAIT   = 3'd3,
        ST_BURST_WAIT = 3'd4
    } state_t;

    state_t              state_r, state_next_s;
    logic [CNT_W-1:0]    cnt_r, cnt_next_s;
    logic                ready_r;
    logic                cmd_valid_r;
    logic [2:0]          cmd_r;
    logic                issue_s;
    logic [2:0]          issue_cmd_s;
    logic                hit_s, miss_s, conflict_s;

    logic                lat_write_r;
    logic [ROW_BITS-1:0] lat_row_r;
    logic [COL_BITS-1:0] lat_col_r;
    logic [BG_W-1:0]     lat_bg_r;
    logic [BA_W-1:0]     lat_ba_r;
    logic [7:0][63:0]    lat_data_r;

    logic [NB-1:0]       open_valid_r;
    logic [ROW_BITS-1:0] open_row_r [NB];
    logic [BG_W+BA_W-1:0] bank_idx_s;
    logic [2:0]          col_cmd_s;
    logic [31:0]         hit_cnt_r, miss_cnt_r, conflict_cnt_r;

    // With power-of-two geometry, bg*BANKS_PER_GROUP+ba is a plain concatenation.
    assign bank_idx_s = {lat_bg_r, lat_ba_r};
    assign col_cmd_s  = lat_write_r ? CMD_WRITE : CMD_READ;

    // Next-state, command selection and request classification
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        issue_s      = 1'b0;
        issue_cmd_s  = CMD_NONE;
        hit_s        = 1'b0;
        miss_s       = 1'b0;
        conflict_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (req_valid_in) begin
                    state_next_s = ST_DECIDE;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_DECIDE: begin
                issue_s = 1'b1;
                if (!open_valid_r[bank_idx_s]) begin
                    miss_s       = 1'b1;
                    issue_cmd_s  = CMD_ACT;
                    state_next_s = ST_ACT_WAIT;
                    cnt_next_s   = ACT_LOAD;
                end else if (open_row_r[bank_idx_s] == lat_row_r) begin
                    hit_s        = 1'b1;
                    issue_cmd_s  = col_cmd_s;
                    state_next_s = ST_BURST_WAIT;
                    cnt_next_s   = BURST_LOAD;
                end else begin
                    conflict_s   = 1'b1;
                    issue_cmd_s  = CMD_PRE;
                    state_next_s = ST_PRE_WAIT;
                    cnt_next_s   = PRE_LOAD;
                end
            end
            ST_PRE_WAIT: begin
                if (cnt_r == '0) begin
                    issue_s      = 1'b1;
                    issue_cmd_s  = CMD_ACT;
                    state_next_s = ST_ACT_WAIT;
                    cnt_next_s   = ACT_LOAD;
                end else begin
                    cnt_next_s = cnt_r - 1'b1;
                end
            end
            ST_ACT_WAIT: begin
                if (cnt_r == '0) begin
                    issue_s      = 1'b1;
                    issue_cmd_s  = col_cmd_s;
                    state_next_s = ST_BURST_WAIT;
                    cnt_next_s   = BURST_LOAD;
                end else begin
                    cnt_next_s = cnt_r - 1'b1;
                end
            end
            ST_BURST_WAIT: begin
                if (cnt_r == '0) begin
                    state_next_s = ST_IDLE;
                end else begin
                    cnt_next_s = cnt_r - 1'b1;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
                cnt_next_s   = '0;
            end
        endcase
    end

    // State, spacing counter, ready flag and command pulse registers
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_r     <= ST_IDLE;
            cnt_r       <= '0;
            ready_r     <= 1'b1;
            cmd_valid_r <= 1'b0;
            cmd_r       <= CMD_NONE;
        end else begin
            state_r     <= state_next_s;
            cnt_r       <= cnt_next_s;
            ready_r     <= (state_next_s == ST_IDLE);
            cmd_valid_r <= issue_s;
            cmd_r       <= issue_cmd_s;
        end
    end

    // Request capture on accept; the latched fields drive every command of the sequence
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            lat_write_r <= 1'b0;
            lat_row_r   <= '0;
            lat_col_r   <= '0;
            lat_bg_r    <= '0;
            lat_ba_r    <= '0;
            lat_data_r  <= '0;
        end else if (req_valid_in && ready_r) begin
            lat_write_r <= req_write_in;
            lat_row_r   <= req_row_in;
            lat_col_r   <= req_col_in;
            lat_bg_r    <= req_bg_in;
            lat_ba_r    <= req_ba_in;
            lat_data_r  <= req_data_in;
        end else begin
            lat_write_r <= lat_write_r;
        end
    end

    // Open-page table: PRECHARGE closes the bank, ACTIVATE opens it at the latched row
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            open_valid_r <= '0;
            for (int i = 0; i < NB; i++) begin
                open_row_r[i] <= '0;
            end
        end else if (issue_s && (issue_cmd_s == CMD_PRE)) begin
            open_valid_r[bank_idx_s] <= 1'b0;
        end else if (issue_s && (issue_cmd_s == CMD_ACT)) begin
            open_valid_r[bank_idx_s] <= 1'b1;
            open_row_r[bank_idx_s]   <= lat_row_r;
        end else begin
            open_valid_r <= open_valid_r;
        end
    end

    // Classification counters, bumped at the end of DECIDE and wrapping naturally
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            hit_cnt_r      <= 32'd0;
            miss_cnt_r     <= 32'd0;
            conflict_cnt_r <= 32'd0;
        end else begin
            hit_cnt_r      <= hit_cnt_r + {31'd0, hit_s};
            miss_cnt_r     <= miss_cnt_r + {31'd0, miss_s};
            conflict_cnt_r <= conflict_cnt_r + {31'd0, conflict_s};
        end
    end

    assign req_ready_out      = ready_r;
    assign cmd_valid_out      = cmd_valid_r;
    assign cmd_out            = cmd_r;
    assign cmd_bg_out         = lat_bg_r;
    assign cmd_ba_out         = lat_ba_r;
    assign cmd_row_out        = lat_row_r;
    assign cmd_col_out        = lat_col_r;
    assign cmd_data_out       = lat_data_r;
    assign hit_count_out      = hit_cnt_r;
    assign miss_count_out     = miss_cnt_r;
    assign conflict_count_out = conflict_cnt_r;
endmodule

// File: tb/tb_bank_cmd_scheduler.sv
// Directed bench for bank_cmd_scheduler: miss, hit, conflict, independent bank,
// mid-sequence reset and a held request while busy, all with hand-computed cycle timing.
module tb_bank_cmd_scheduler;
    logic             clk_in = 1'b0;
    logic             rst_in;
    logic             req_valid_in;
    logic             req_ready_out;
    logic             req_write_in;
    logic [7:0]       req_row_in;
    logic [3:0]       req_col_in;
    logic [1:0]       req_bg_in;
    logic [0:0]       req_ba_in;
    logic [7:0][63:0] req_data_in;
    logic             cmd_valid_out;
    logic [2:0]       cmd_out;
    logic [1:0]       cmd_bg_out;
    logic [0:0]       cmd_ba_out;
    logic [7:0]       cmd_row_out;
    logic [3:0]       cmd_col_out;
    logic [7:0][63:0] cmd_data_out;
    logic [31:0]      hit_count_out, miss_count_out, conflict_count_out;

    int checks   = 0;
    int failures = 0;
    int edge_cnt = 0;

    localparam logic [2:0] C_RD = 3'd0, C_WR = 3'd1, C_ACT = 3'd2, C_PRE = 3'd3, C_NONE = 3'd7;

    bank_cmd_scheduler dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .req_valid_in(req_valid_in), .req_ready_out(req_ready_out),
        .req_write_in(req_write_in), .req_row_in(req_row_in), .req_col_in(req_col_in),
        .req_bg_in(req_bg_in), .req_ba_in(req_ba_in), .req_data_in(req_data_in),
        .cmd_valid_out(cmd_valid_out), .cmd_out(cmd_out),
        .cmd_bg_out(cmd_bg_out), .cmd_ba_out(cmd_ba_out),
        .cmd_row_out(cmd_row_out), .cmd_col_out(cmd_col_out), .cmd_data_out(cmd_data_out),
        .hit_count_out(hit_count_out), .miss_count_out(miss_count_out),
        .conflict_count_out(conflict_count_out)
    );

    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) edge_cnt <= edge_cnt + 1;

    // Drive one request from a negedge; it is accepted at the following edge A.
    task automatic do_req(input logic wr, input logic [7:0] row, input logic [3:0] col,
                          input logic [1:0] bg, input logic ba, input logic [63:0] base);
        req_write_in = wr; req_row_in = row; req_col_in = col; req_bg_in = bg; req_ba_in = ba;
        for (int i = 0; i < 8; i++) req_data_in[i] = base + 64'(i);
        req_valid_in = 1'b1;
        @(posedge clk_in);
        #1 req_valid_in = 1'b0;
    endtask

    // Walk cycles A..A+last, checking pulses at k1/k2/k3 (0 = unused) and ready from rdy_k on.
    task automatic walk(input string nm, input int last, input int k1, input logic [2:0] c1,
                        input int k2, input logic [2:0] c2, input int k3, input logic [2:0] c3,
                        input int rdy_k);
        logic       ev;
        logic [2:0] ec;
        for (int k = 0; k <= last; k++) begin
            @(negedge clk_in);
            ev = 1'b0; ec = C_NONE;
            if (k1 != 0 && k == k1) begin ev = 1'b1; ec = c1; end
            if (k2 != 0 && k == k2) begin ev = 1'b1; ec = c2; end
            if (k3 != 0 && k == k3) begin ev = 1'b1; ec = c3; end
            checks++;
            if (cmd_valid_out !== ev || cmd_out !== ec) begin
                failures++;
                $display("FAIL %s_cmd k=%0d got v=%0b c=%0d want v=%0b c=%0d", nm, k, cmd_valid_out, cmd_out, ev, ec);
            end
            checks++;
            if (req_ready_out !== (k >= rdy_k)) begin
                failures++;
                $display("FAIL %s_ready k=%0d got %0b want %0b", nm, k, req_ready_out, (k >= rdy_k));
            end
        end
    endtask

    task automatic check_addr(input string nm, input logic [7:0] row, input logic [3:0] col,
                              input logic [1:0] bg, input logic ba);
        checks++;
        if (cmd_row_out !== row || cmd_col_out !== col || cmd_bg_out !== bg || cmd_ba_out !== ba) begin
            failures++;
            $display("FAIL %s_addr got row=%h col=%h bg=%0d ba=%0d want row=%h col=%h bg=%0d ba=%0d",
                     nm, cmd_row_out, cmd_col_out, cmd_bg_out, cmd_ba_out, row, col, bg, ba);
        end
    endtask

    task automatic check_counts(input string nm, input int h, input int m, input int c);
        checks++;
        if (hit_count_out !== 32'(h) || miss_count_out !== 32'(m) || conflict_count_out !== 32'(c)) begin
            failures++;
            $display("FAIL %s_counts got h=%0d m=%0d c=%0d want h=%0d m=%0d c=%0d",
                     nm, hit_count_out, miss_count_out, conflict_count_out, h, m, c);
        end
    endtask

    task automatic test_reset();
        rst_in = 1'b1; req_valid_in = 1'b0; req_write_in = 1'b0; req_row_in = '0;
        req_col_in = '0; req_bg_in = '0; req_ba_in = '0; req_data_in = '0;
        @(posedge clk_in); @(posedge clk_in);
        #1 rst_in = 1'b0;
        @(negedge clk_in);
        checks++;
        if (cmd_valid_out !== 1'b0 || cmd_out !== C_NONE || req_ready_out !== 1'b1) begin
            failures++;
            $display("FAIL reset_ctrl got v=%0b c=%0d rdy=%0b want v=0 c=7 rdy=1", cmd_valid_out, cmd_out, req_ready_out);
        end
        check_addr("reset", 8'h00, 4'h0, 2'd0, 1'b0);
        checks++;
        if (cmd_data_out !== '0) begin
            failures++;
            $display("FAIL reset_data got %h want 0", cmd_data_out[0]);
        end
        check_counts("reset", 0, 0, 0);
    endtask

    task automatic test_miss();
        while (edge_cnt < 9) @(negedge clk_in);
        do_req(1'b0, 8'h12, 4'd3, 2'd1, 1'b0, 64'd0);   // accepted at edge 10
        walk("miss", 17, 1, C_ACT, 9, C_RD, 0, C_NONE, 17);
        check_addr("miss", 8'h12, 4'd3, 2'd1, 1'b0);
        check_counts("miss", 0, 1, 0);
    endtask

    task automatic test_hit_write();
        do_req(1'b1, 8'h12, 4'd5, 2'd1, 1'b0, 64'd0);
        @(negedge clk_in);
        @(negedge clk_in);
        checks++;
        if (cmd_valid_out !== 1'b1 || cmd_out !== C_WR) begin
            failures++;
            $display("FAIL hit_write_cmd got v=%0b c=%0d want v=1 c=1", cmd_valid_out, cmd_out);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (cmd_data_out[i] !== 64'(i)) begin
                failures++;
                $display("FAIL hit_data beat%0d got %h want %h", i, cmd_data_out[i], 64'(i));
            end
        end
        check_addr("hit", 8'h12, 4'd5, 2'd1, 1'b0);
        walk("hit_tail", 7, 0, C_NONE, 0, C_NONE, 0, C_NONE, 7);   // k here is offset by 2
        check_counts("hit", 1, 1, 0);
    endtask

    task automatic test_conflict();
        do_req(1'b0, 8'h34, 4'd7, 2'd1, 1'b0, 64'd0);
        walk("conflict", 22, 1, C_PRE, 6, C_ACT, 14, C_RD, 22);
        check_addr("conflict", 8'h34, 4'd7, 2'd1, 1'b0);
        check_counts("conflict", 1, 1, 1);
    endtask

    task automatic test_other_bank();
        do_req(1'b0, 8'h34, 4'd1, 2'd2, 1'b1, 64'd0);
        walk("other_bank", 17, 1, C_ACT, 9, C_RD, 0, C_NONE, 17);
        check_counts("other_bank", 1, 2, 1);
        do_req(1'b0, 8'h34, 4'd2, 2'd1, 1'b0, 64'd0);
        walk("reopen_hit", 9, 1, C_RD, 0, C_NONE, 0, C_NONE, 9);
        check_counts("reopen_hit", 2, 2, 1);
    endtask

    task automatic test_mid_reset();
        do_req(1'b0, 8'h56, 4'd0, 2'd1, 1'b0, 64'd0);
        for (int k = 0; k <= 12; k++) begin
            @(negedge clk_in);
            checks++;
            if (cmd_valid_out !== (k == 1) || cmd_out !== ((k == 1) ? C_PRE : C_NONE)) begin
                failures++;
                $display("FAIL mid_reset_cmd k=%0d got v=%0b c=%0d", k, cmd_valid_out, cmd_out);
            end
            checks++;
            if (req_ready_out !== (k >= 4)) begin
                failures++;
                $display("FAIL mid_reset_ready k=%0d got %0b want %0b", k, req_ready_out, (k >= 4));
            end
            if (k == 3) begin
                check_counts("pre_reset", 2, 2, 2);
                rst_in = 1'b1;
            end
            if (k == 4) begin
                rst_in = 1'b0;
                check_counts("post_reset", 0, 0, 0);
            end
        end
        do_req(1'b0, 8'h56, 4'd0, 2'd1, 1'b0, 64'd0);
        walk("after_reset", 17, 1, C_ACT, 9, C_RD, 0, C_NONE, 17);
        check_counts("after_reset", 0, 1, 0);
    endtask

    task automatic test_held_request();
        logic       ev;
        logic [2:0] ec;
        do_req(1'b1, 8'h77, 4'd9, 2'd0, 1'b1, 64'hA5A5_0000_0000_0000);
        req_valid_in = 1'b1;
        for (int k = 0; k <= 35; k++) begin
            @(negedge clk_in);
            ev = (k == 1 || k == 9 || k == 19 || k == 27);
            ec = (k == 1 || k == 19) ? C_ACT : (k == 9) ? C_WR : (k == 27) ? C_RD : C_NONE;
            checks++;
            if (cmd_valid_out !== ev || cmd_out !== ec) begin
                failures++;
                $display("FAIL held_cmd k=%0d got v=%0b c=%0d want v=%0b c=%0d", k, cmd_valid_out, cmd_out, ev, ec);
            end
            checks++;
            if (req_ready_out !== (k == 17 || k == 35)) begin
                failures++;
                $display("FAIL held_ready k=%0d got %0b", k, req_ready_out);
            end
            if (k == 9) begin
                check_addr("held_first", 8'h77, 4'd9, 2'd0, 1'b1);
                checks++;
                if (cmd_data_out[3] !== 64'hA5A5_0000_0000_0003) begin
                    failures++;
                    $display("FAIL held_data got %h want a5a5000000000003", cmd_data_out[3]);
                end
            end
            if (k == 27) check_addr("held_second", 8'h99, 4'd4, 2'd3, 1'b0);
            if (k < 16) begin
                req_write_in = k[0]; req_row_in = 8'(8'hA0 + k); req_col_in = 4'(k);
                req_bg_in = 2'(k); req_ba_in = 1'(k); req_data_in[3] = 64'(k);
            end else if (k == 16) begin
                req_write_in = 1'b0; req_row_in = 8'h99; req_col_in = 4'd4;
                req_bg_in = 2'd3; req_ba_in = 1'b0;
            end else if (k == 18) begin
                req_valid_in = 1'b0;
            end
        end
        check_counts("held", 0, 3, 0);
    endtask

    initial begin
        test_reset();
        test_miss();
        test_hit_write();
        test_conflict();
        test_other_bank();
        test_mid_reset();
        test_held_request();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1);
    end
endmodule
